// File: rtl/board_update.sv
// Authoritative chess board: per-piece square and alive bit for both sides.
// A confirmed request relocates one piece, captures on the target, passes the turn.
module board_update (
  input  logic        clk,
  input  logic        RST,
  input  logic        en,
  input  logic        player,
  input  logic [5:0]  move_input,
  input  logic [3:0]  piece_number,
  output logic [95:0] location_vectors_w,
  output logic [95:0] location_vectors_b,
  output logic [15:0] alive_vectors_w,
  output logic [15:0] alive_vectors_b,
  output logic [1:0]  dbg_state,
  output logic        output_player,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MOVE    = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [5:0]  loc_w [16];
  logic [5:0]  loc_b [16];
  logic [15:0] alive_w, alive_b;

  logic        en_s, en_q, pl_s;
  logic [3:0]  pn_s;
  logic [5:0]  mv_s;
  logic        pl_q;
  logic [3:0]  pn_q;
  logic [5:0]  dst_q;
  logic        valid_q;
  logic        out_pl;
  logic        done_q;

  logic [15:0] hit_w, hit_b;
  logic [15:0] own_hit, sel_mask;
  logic        sel_alive, move_ok, start;

  function automatic logic [5:0] home(input logic blk, input logic [3:0] id);
    logic [2:0] x, y;
    if (!id[3]) begin
      x = id[2:0];
      y = blk ? 3'd6 : 3'd1;
    end else begin
      y = blk ? 3'd7 : 3'd0;
      case (id[2:0])
        3'd0:    x = 3'd0;
        3'd1:    x = 3'd7;
        3'd2:    x = 3'd1;
        3'd3:    x = 3'd6;
        3'd4:    x = 3'd2;
        3'd5:    x = 3'd5;
        3'd6:    x = 3'd3;
        default: x = 3'd4;
      endcase
    end
    return {y, x};
  endfunction

  // a start needs the registered en to rise, so held en never retriggers
  assign start = en_s & ~en_q;

  always_comb begin
    hit_w = '0;
    hit_b = '0;
    for (int i = 0; i < 16; i++) begin
      hit_w[i] = alive_w[i] && (loc_w[i] == dst_q);
      hit_b[i] = alive_b[i] && (loc_b[i] == dst_q);
    end
  end

  always_comb begin
    sel_mask  = 16'd1 << pn_q;
    own_hit   = pl_q ? hit_b : hit_w;
    sel_alive = pl_q ? alive_b[pn_q] : alive_w[pn_q];
    move_ok   = sel_alive && ((own_hit & ~sel_mask) == '0);
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = MOVE;
      MOVE:    state_nx = CAPTURE;
      CAPTURE: state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 16; i++) begin
        loc_w[i] <= home(1'b0, 4'(i));
        loc_b[i] <= home(1'b1, 4'(i));
      end
      alive_w <= '1;
      alive_b <= '1;
      en_s    <= 1'b0;
      en_q    <= 1'b0;
      pl_s    <= 1'b0;
      pn_s    <= '0;
      mv_s    <= '0;
      pl_q    <= 1'b0;
      pn_q    <= '0;
      dst_q   <= '0;
      valid_q <= 1'b0;
      out_pl  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      en_s   <= en;
      en_q   <= en_s;
      pl_s   <= player;
      pn_s   <= piece_number;
      mv_s   <= move_input;
      done_q <= (state == CAPTURE);
      unique case (state)
        IDLE: begin
          if (start) begin
            pl_q  <= pl_s;
            pn_q  <= pn_s;
            dst_q <= mv_s;
          end
        end
        MOVE: begin
          valid_q <= move_ok;
          if (move_ok) begin
            if (pl_q) loc_b[pn_q] <= dst_q;
            else      loc_w[pn_q] <= dst_q;
          end
        end
        CAPTURE: begin
          // captured pieces keep their last square; only alive drops
          if (valid_q) begin
            if (pl_q) alive_w <= alive_w & ~hit_w;
            else      alive_b <= alive_b & ~hit_b;
            out_pl <= ~pl_q;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_pack
    assign location_vectors_w[6*g +: 6] = loc_w[g];
    assign location_vectors_b[6*g +: 6] = loc_b[g];
  end

  assign alive_vectors_w = alive_w;
  assign alive_vectors_b = alive_b;
  assign dbg_state       = state;
  assign output_player   = out_pl;
  assign done            = done_q;

endmodule

// File: tb/tb_board_update.sv
// Bench for board_update: vector table against a board model,
// scoreboard popped on each done pulse, plus reset/held-en sequences.
module tb_board_update;

  logic        clk;
  logic        RST;
  logic        en;
  logic        player;
  logic [5:0]  move_input;
  logic [3:0]  piece_number;
  logic [95:0] location_vectors_w;
  logic [95:0] location_vectors_b;
  logic [15:0] alive_vectors_w;
  logic [15:0] alive_vectors_b;
  logic [1:0]  dbg_state;
  logic        output_player;
  logic        done;

  board_update dut (
    .clk                (clk),
    .RST                (RST),
    .en                 (en),
    .player             (player),
    .move_input         (move_input),
    .piece_number       (piece_number),
    .location_vectors_w (location_vectors_w),
    .location_vectors_b (location_vectors_b),
    .alive_vectors_w    (alive_vectors_w),
    .alive_vectors_b    (alive_vectors_b),
    .dbg_state          (dbg_state),
    .output_player      (output_player),
    .done               (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    logic [95:0] lw;
    logic [95:0] lb;
    logic [15:0] aw;
    logic [15:0] ab;
    logic        pl;
    int          cyc;
  } exp_t;

  typedef struct {
    logic       p;
    logic [3:0] id;
    logic [5:0] dst;
  } vec_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  logic [95:0] mw, mb;
  logic [15:0] aw, ab;
  logic        mp;

  task automatic chk(input string name, input logic [95:0] act,
                     input logic [95:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic logic [5:0] start_sq(input logic blk, input logic [3:0] id);
    logic [2:0] f;
    logic [2:0] r;
    case (id)
      4'd8:    f = 3'd0;
      4'd9:    f = 3'd7;
      4'd10:   f = 3'd1;
      4'd11:   f = 3'd6;
      4'd12:   f = 3'd2;
      4'd13:   f = 3'd5;
      4'd14:   f = 3'd3;
      4'd15:   f = 3'd4;
      default: f = id[2:0];
    endcase
    if (id < 4'd8) r = blk ? 3'd6 : 3'd1;
    else           r = blk ? 3'd7 : 3'd0;
    return {r, f};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      mw[6*i +: 6] = start_sq(1'b0, 4'(i));
      mb[6*i +: 6] = start_sq(1'b1, 4'(i));
    end
    aw = 16'hFFFF;
    ab = 16'hFFFF;
    mp = 1'b0;
  endtask

  task automatic model_move(input logic p, input logic [3:0] id,
                            input logic [5:0] dst);
    logic [95:0] oloc, xloc;
    logic [15:0] oal, xal;
    logic        ok;
    oloc = p ? mb : mw;
    xloc = p ? mw : mb;
    oal  = p ? ab : aw;
    xal  = p ? aw : ab;
    ok   = oal[id];
    for (int j = 0; j < 16; j++)
      if (j != int'(id) && oal[j] && oloc[6*j +: 6] == dst) ok = 1'b0;
    if (ok) begin
      oloc[6*id +: 6] = dst;
      for (int j = 0; j < 16; j++)
        if (xal[j] && xloc[6*j +: 6] == dst) xal[j] = 1'b0;
      mp = ~p;
    end
    if (p) begin mb = oloc; ab = oal; mw = xloc; aw = xal; end
    else   begin mw = oloc; aw = oal; mb = xloc; ab = xal; end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (RST && done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL done_extra: got done=1 at cyc %0d want 0", cyc);
      end else begin
        e = sb.pop_front();
        chk("done_latency", 96'(cyc), 96'(e.cyc));
        chk("done_state", 96'(dbg_state), 96'd3);
        chk("loc_w", location_vectors_w, e.lw);
        chk("loc_b", location_vectors_b, e.lb);
        chk("alive_w", 96'(alive_vectors_w), 96'(e.aw));
        chk("alive_b", 96'(alive_vectors_b), 96'(e.ab));
        chk("player", 96'(output_player), 96'(e.pl));
      end
    end
  end

  task automatic run_vec(input logic p, input logic [3:0] id,
                         input logic [5:0] dst, input int hold);
    exp_t e;
    @(negedge clk);
    player       = p;
    piece_number = id;
    move_input   = dst;
    en           = 1'b1;
    model_move(p, id, dst);
    e.lw  = mw;
    e.lb  = mb;
    e.aw  = aw;
    e.ab  = ab;
    e.pl  = mp;
    e.cyc = cyc + 4;
    sb.push_back(e);
    repeat (hold) @(negedge clk);
    en = 1'b0;
    for (int k = 0; k < 16 && sb.size() != 0; k++) @(posedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done want 1 pulse");
      sb.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    logic [95:0] w, b;
    w = location_vectors_w;
    b = location_vectors_b;
    chk({tag, "_w0"}, 96'(w[5:0]), 96'(6'o10));
    chk({tag, "_wk"}, 96'(w[95:90]), 96'(6'o04));
    chk({tag, "_bk"}, 96'(b[95:90]), 96'(6'o74));
    chk({tag, "_locw"}, w, mw);
    chk({tag, "_locb"}, b, mb);
    chk({tag, "_aw"}, 96'(alive_vectors_w), 96'(16'hFFFF));
    chk({tag, "_ab"}, 96'(alive_vectors_b), 96'(16'hFFFF));
    chk({tag, "_pl"}, 96'(output_player), 96'd0);
    chk({tag, "_done"}, 96'(done), 96'd0);
    chk({tag, "_st"}, 96'(dbg_state), 96'd0);
  endtask

  vec_t vt[11];

  initial begin
    vt[0]  = '{1'b0, 4'd8,  6'o01};
    vt[1]  = '{1'b0, 4'd4,  6'o34};
    vt[2]  = '{1'b1, 4'd3,  6'o53};
    vt[3]  = '{1'b0, 4'd4,  6'o44};
    vt[4]  = '{1'b1, 4'd0,  6'o50};
    vt[5]  = '{1'b0, 4'd4,  6'o53};
    vt[6]  = '{1'b1, 4'd3,  6'o43};
    vt[7]  = '{1'b1, 4'd15, 6'o74};
    vt[8]  = '{1'b0, 4'd3,  6'o53};
    vt[9]  = '{1'b1, 4'd14, 6'o04};
    vt[10] = '{1'b0, 4'd15, 6'o33};

    RST          = 1'b0;
    en           = 1'b0;
    player       = 1'b0;
    piece_number = '0;
    move_input   = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset("rst");
    RST = 1'b1;
    @(negedge clk);
    check_reset("rel");

    for (int i = 0; i < 11; i++) begin
      run_vec(vt[i].p, vt[i].id, vt[i].dst, 1);
      if (i == 0)
        chk("own_occ_pl", 96'(output_player), 96'd0);
      if (i == 1)
        chk("simple_w4", 96'(location_vectors_w[29:24]), 96'(6'o34));
      if (i == 5) begin
        chk("cap_ab", 96'(alive_vectors_b), 96'(16'hFFF7));
        chk("cap_b3", 96'(location_vectors_b[23:18]), 96'(6'o53));
        chk("cap_pl", 96'(output_player), 96'd1);
      end
      if (i == 6)
        chk("dead_b3", 96'(location_vectors_b[23:18]), 96'(6'o53));
    end

    // en held high: exactly one update
    run_vec(1'b1, 4'd1, 6'o41, 10);

    // reset landing while the update sits in CAPTURE
    @(negedge clk);
    player       = 1'b0;
    piece_number = 4'd5;
    move_input   = 6'o35;
    en           = 1'b1;
    @(negedge clk);
    en = 1'b0;
    for (int k = 0; k < 10 && dbg_state != 2'd2; k++) @(negedge clk);
    chk("mid_capture", 96'(dbg_state), 96'd2);
    RST = 1'b0;
    #1;
    model_reset();
    check_reset("mid");
    @(negedge clk);
    RST = 1'b1;
    repeat (6) @(negedge clk);
    check_reset("post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/board_update.md
Name: board_update

Overview:
- Holds the authoritative chess board state: a 6-bit square location and an alive flag for each of 16 white and 16 black pieces.
- On a confirmed move request, it relocates the selected piece of the side to move and captures any opponent piece on the destination square.
- It then hands the turn to the other side and pulses done, which starts downstream move generation.
- It sits between the keyboard/LCD selection logic and the move generator.

Parameters:
- none

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- RST  input  1  asynchronous, active-low reset
- en  input  1  move request; a rising edge sampled in IDLE starts one update
- player  input  1  side to move: 0 = white, 1 = black; sampled with en
- move_input  input  6  destination square {y[2:0], x[2:0]}, where y = rank (0 = white back rank) and x = file
- piece_number  input  4  ID of the piece to move, within the side given by player
- location_vectors_w  output  96  white piece locations; piece i at bits [6i+5:6i]
- location_vectors_b  output  96  black piece locations, same packing
- alive_vectors_w  output  16  bit i = 1 when white piece i is on the board
- alive_vectors_b  output  16  bit i = 1 when black piece i is on the board
- dbg_state  output  2  current FSM state encoding
- output_player  output  1  side to move after the last update
- done  output  1  one-cycle pulse when an update completes

Behaviour:
- Piece IDs: 0-7 pawns on files x = 0..7; 8/9 rooks (x = 0/7); 10/11 knights (x = 1/6); 12/13 bishops (x = 2/5); 14 queen (x = 3); 15 king (x = 4).
- Reset state (RST low, asynchronous):
  - white pawns at y = 1, white pieces at y = 0; black pawns at y = 6, black pieces at y = 7; files as listed above.
  - all alive bits = 1; output_player = 0; done = 0; FSM = IDLE.
  - Example: white piece 0 = 6'o10, white king = 6'o04, black king = 6'o74.
- FSM encoding: IDLE = 0, MOVE = 1, CAPTURE = 2, DONE = 3; dbg_state always reflects the current state.
- IDLE:
  - en is registered each cycle; an update starts only when en = 1 and its previous sample was 0.
  - On start, latch player, piece_number and move_input, then go to MOVE.
  - en held high does not retrigger.
- MOVE:
  - Validity requires both: the selected piece is alive, and no alive piece of the mover's own side (other than itself) occupies the destination.
  - If valid: write the destination into the selected piece's location field and set a valid flag.
  - If invalid: change nothing and clear the valid flag.
  - Next state: CAPTURE.
- CAPTURE:
  - If valid, every opponent piece that is alive and whose location equals the destination has its alive bit cleared in parallel.
  - A captured piece's location field is left unchanged.
  - Next state: DONE.
- DONE:
  - done = 1 for exactly this one cycle.
  - output_player = ~latched player if valid; otherwise it keeps its prior value.
  - Next state: IDLE.
- Latency: done is high during the 4th cycle after the en rising-edge sample, i.e. sample edge + 3 edges.
- While busy (MOVE/CAPTURE/DONE), en and all other inputs are ignored.
- Moving a piece onto its own current square counts as valid: the location is unchanged and the turn still passes.
- An asserted reset mid-update aborts immediately to the initial board with done = 0.
- All outputs are driven directly from registers; there are no combinational paths from inputs to outputs.
- The block does no chess-legality checking beyond the alive and own-occupancy checks above.

Test Plan:
- Reset:
  - Apply RST = 0, then release.
  - Required: location_vectors_w[5:0] = 6'o10, [95:90] = 6'o04; location_vectors_b[95:90] = 6'o74; both alive vectors = 16'hFFFF; output_player = 0; done = 0; dbg_state = 0.
- Simple move:
  - Drive player = 0, piece_number = 4, move_input = 6'o34, then an en pulse.
  - Required: white piece 4 = 6'o34; done pulses once, 3 edges after sampling; output_player = 1; alive vectors unchanged.
- Capture:
  - Place white piece 4 on 6'o44 and black piece 3 on 6'o53.
  - Move white piece 4 to 6'o53.
  - Required: alive_vectors_b = 16'hFFF7; black piece 3's location stays 6'o53; output_player toggles.
- Own-occupied destination:
  - Drive player = 0, piece 8 (at 6'o00) to 6'o01, which holds the white knight.
  - Required: no vector changes; done pulses; output_player stays 0.
- Dead piece and held en:
  - Move a captured piece: required no change and done pulses.
  - Hold en high for 10 cycles: required exactly one done pulse.
- Reset mid-update:
  - Assert RST while the FSM is in CAPTURE.
  - Required: initial board restored immediately, done = 0, dbg_state = 0.
